// File: rtl/pooling_pkg.sv
// Shared constants for the pooling stage: lane geometry, window encoding and FSM states.
// Average pooling is only compiled in when POOL_AVG_EN is defined.
package pooling_pkg;

  localparam int MAT_MUL_SIZE = 4;
  localparam int DWIDTH       = 8;
  localparam int ACC_W        = DWIDTH + 4;
  localparam int RED_LANES    = 4;
  localparam int IDX_W        = $clog2(MAT_MUL_SIZE);

  localparam logic [1:0] WIN_ENC_1 = 2'b00;
  localparam logic [1:0] WIN_ENC_2 = 2'b01;
  localparam logic [1:0] WIN_ENC_4 = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Encodings 10 and 11 both select a window of four rows.
  function automatic logic [2:0] win_size(input logic [1:0] enc);
    case (enc)
      WIN_ENC_1: return 3'd1;
      WIN_ENC_2: return 3'd2;
      WIN_ENC_4: return 3'd4;
      default:   return 3'd4;
    endcase
  endfunction

`ifdef POOL_AVG_EN
  // Divide by W*W as a right shift by log2(W*W).
  function automatic logic [2:0] avg_shift(input logic [2:0] w);
    case (w)
      3'd1:    return 3'd0;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction
`endif

endpackage

// File: rtl/pool_lane_reduce.sv
// Combinational W-to-1 lane reducer (signed max, or sum under POOL_AVG_EN), sized for W=4.
module pool_lane_reduce
  import pooling_pkg::*;
(
`ifdef POOL_AVG_EN
  input  logic                        avg,
`endif
  input  logic [2:0]                  win,
  input  logic [RED_LANES*ACC_W-1:0]  lanes,
  output logic signed [ACC_W-1:0]     result
);

  logic signed [ACC_W-1:0] cur;

  // Fold lanes 1..W-1 into lane 0; lanes at or beyond W are ignored.
  always_comb begin
    result = lanes[ACC_W-1:0];
    cur    = '0;
    for (int k = 1; k < RED_LANES; k++) begin
      cur = lanes[k*ACC_W +: ACC_W];
`ifdef POOL_AVG_EN
      if (3'(k) < win) begin
        result = avg ? (result + cur) : ((cur > result) ? cur : result);
      end else begin
        result = result;
      end
`else
      result = ((3'(k) < win) && (cur > result)) ? cur : result;
`endif
    end
  end

endmodule

// File: rtl/pooling.sv
// Row pooling over W consecutive valid rows with horizontal W-lane reduction.
// Optional average pooling (adds port pool_avg) is enabled by defining POOL_AVG_EN.
module pooling
  import pooling_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_pool,
  input  logic [1:0]                     pool_window,
`ifdef POOL_AVG_EN
  input  logic                           pool_avg,
`endif
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_data_available,
  output logic                           done_pool
);

  state_t state_r, state_next;
  logic [2:0] count_r, win_r, win_in, red_win;
  logic       emit, load, from_acc;
  logic       out_valid_r, done_r;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] out_r, out_next;
  logic signed [ACC_W-1:0] in_ext  [MAT_MUL_SIZE];
  logic signed [ACC_W-1:0] acc_r   [MAT_MUL_SIZE];
  logic signed [ACC_W-1:0] merged  [MAT_MUL_SIZE];
  logic signed [ACC_W-1:0] red_src [MAT_MUL_SIZE];
  logic signed [ACC_W-1:0] red_res [MAT_MUL_SIZE];
  logic [RED_LANES*ACC_W-1:0] red_in [MAT_MUL_SIZE];
`ifdef POOL_AVG_EN
  logic avg_r, red_avg;
  assign red_avg = (state_r == ST_IDLE) ? pool_avg : avg_r;
`endif

  assign win_in  = win_size(pool_window);
  assign red_win = (state_r == ST_IDLE) ? win_in : win_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // FSM next state: emit on the W-th row or when the input stream stalls mid-window
  always_comb begin
    state_next = state_r;
    emit       = 1'b0;
    load       = 1'b0;
    from_acc   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_pool && in_data_available) begin
          if (win_in == 3'd1) begin
            emit = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = ST_ACCUM;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (!enable_pool) begin
          state_next = ST_IDLE;
        end else if (!in_data_available) begin
          emit       = 1'b1;
          from_acc   = 1'b1;
          state_next = ST_IDLE;
        end else if ((count_r + 3'd1) == win_r) begin
          emit       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          load = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: bypass is purely combinational, pooling drives registered results
  always_comb begin
    if (enable_pool) begin
      out_data           = out_r;
      out_data_available = out_valid_r;
      done_pool          = done_r;
    end else begin
      out_data           = inp_data;
      out_data_available = in_data_available;
      done_pool          = 1'b1;
    end
  end

  // Vertical merge of the incoming row into the per-lane accumulators
  always_comb begin
    for (int i = 0; i < MAT_MUL_SIZE; i++) begin
      in_ext[i] = ACC_W'(signed'(inp_data[i*DWIDTH +: DWIDTH]));
      if (state_r == ST_IDLE) begin
        merged[i] = in_ext[i];
`ifdef POOL_AVG_EN
      end else if (avg_r) begin
        merged[i] = acc_r[i] + in_ext[i];
`endif
      end else begin
        merged[i] = (in_ext[i] > acc_r[i]) ? in_ext[i] : acc_r[i];
      end
      red_src[i] = from_acc ? acc_r[i] : merged[i];
    end
  end

  // Gather lanes j*W .. j*W+W-1 for output lane j
  always_comb begin
    int idx;
    for (int j = 0; j < MAT_MUL_SIZE; j++) begin
      red_in[j] = '0;
      for (int k = 0; k < RED_LANES; k++) begin
        idx = j * int'(red_win) + k;
        if ((k < int'(red_win)) && (idx < MAT_MUL_SIZE)) begin
          red_in[j][k*ACC_W +: ACC_W] = red_src[idx[IDX_W-1:0]];
        end else begin
          red_in[j][k*ACC_W +: ACC_W] = '0;
        end
      end
    end
  end

  for (genvar g = 0; g < MAT_MUL_SIZE; g++) begin : g_reduce
    pool_lane_reduce u_reduce (
`ifdef POOL_AVG_EN
      .avg    (red_avg),
`endif
      .win    (red_win),
      .lanes  (red_in[g]),
      .result (red_res[g])
    );
  end

  // Output lanes beyond MAT_MUL_SIZE/W are forced to zero
  always_comb begin
    out_next = '0;
    for (int j = 0; j < MAT_MUL_SIZE; j++) begin
      if ((j * int'(red_win)) < MAT_MUL_SIZE) begin
`ifdef POOL_AVG_EN
        out_next[j*DWIDTH +: DWIDTH] = red_avg ? DWIDTH'(red_res[j] >>> avg_shift(red_win))
                                               : DWIDTH'(red_res[j]);
`else
        out_next[j*DWIDTH +: DWIDTH] = DWIDTH'(red_res[j]);
`endif
      end else begin
        out_next[j*DWIDTH +: DWIDTH] = '0;
      end
    end
  end

  // Window bookkeeping, accumulators, result register and stream-done flag
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r     <= 3'd0;
      win_r       <= 3'd1;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      for (int i = 0; i < MAT_MUL_SIZE; i++) acc_r[i] <= '0;
`ifdef POOL_AVG_EN
      avg_r       <= 1'b0;
`endif
    end else begin
      out_valid_r <= emit;
      out_r       <= emit ? out_next : '0;
      if (load) begin
        count_r <= count_r + 3'd1;
        for (int i = 0; i < MAT_MUL_SIZE; i++) acc_r[i] <= merged[i];
      end else if (state_next == ST_IDLE) begin
        count_r <= 3'd0;
      end
      // Window size and mode are latched at window start and held until it closes
      if (state_r == ST_IDLE) begin
        win_r <= win_in;
`ifdef POOL_AVG_EN
        avg_r <= pool_avg;
`endif
      end
      if (out_valid_r && !in_data_available) begin
        done_r <= 1'b1;
      end else if (in_data_available) begin
        done_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pooling.sv
// Self-checking bench for pooling: directed scenarios plus a randomized stream
// checked against a window-list reference model (POOL_AVG_EN adds average cases).
module tb_pooling;

  localparam int M  = 4;
  localparam int DW = 8;
  typedef logic [M*DW-1:0] row_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_pool;
  logic [1:0] pool_window;
  logic       in_data_available;
  row_t       inp_data;
  row_t       out_data;
  logic       out_data_available;
  logic       done_pool;
`ifdef POOL_AVG_EN
  logic       pool_avg;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pooling dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pool        (enable_pool),
    .pool_window        (pool_window),
`ifdef POOL_AVG_EN
    .pool_avg           (pool_avg),
`endif
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t pack4(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic int lane_of(input row_t r, input int i);
    logic signed [DW-1:0] b;
    b = r[i*DW +: DW];
    return int'(b);
  endfunction

  function automatic int wsize(input logic [1:0] e);
    return (e == 2'b00) ? 1 : ((e == 2'b01) ? 2 : 4);
  endfunction

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: reduce every value of every row in group j, then scale for average.
  function automatic row_t ref_pool(input row_t rows[$], input int w, input bit avg);
    row_t r;
    r = '0;
    for (int j = 0; j < M / w; j++) begin
      int  acc;
      bit  first;
      acc   = 0;
      first = 1'b1;
      foreach (rows[n]) begin
        for (int k = 0; k < w; k++) begin
          int v;
          v = lane_of(rows[n], j * w + k);
          if (first) acc = v;
          else if (avg) acc = acc + v;
          else if (v > acc) acc = v;
          first = 1'b0;
        end
      end
      if (avg) acc = floor_div(acc, w * w);
      r[j*DW +: DW] = DW'(acc);
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable_pool = 1'b1; pool_window = 2'b00; in_data_available = 1'b0;
    inp_data = '0;
`ifdef POOL_AVG_EN
    pool_avg = 1'b0;
`endif
    tick(); tick();
    total_cnt++; if (out_data !== '0) $display("FAIL reset_data got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (out_data_available !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_data_available); else pass_cnt++;
    total_cnt++; if (done_pool !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_pool); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    row_t r;
    bit   v;
    enable_pool = 1'b0; in_data_available = 1'b1; inp_data = pack4(1, -2, 3, -4);
    #1;
    total_cnt++; if (out_data !== pack4(1, -2, 3, -4)) $display("FAIL bypass_data got=%h exp=%h", out_data, pack4(1, -2, 3, -4)); else pass_cnt++;
    total_cnt++; if (out_data_available !== 1'b1) $display("FAIL bypass_valid got=%b exp=1", out_data_available); else pass_cnt++;
    total_cnt++; if (done_pool !== 1'b1) $display("FAIL bypass_done got=%b exp=1", done_pool); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      r = row_t'($urandom); v = 1'($urandom_range(0, 1));
      inp_data = r; in_data_available = v;
      #2;
      total_cnt++; if (out_data !== r) $display("FAIL bypass_rand_data got=%h exp=%h", out_data, r); else pass_cnt++;
      total_cnt++; if (out_data_available !== v) $display("FAIL bypass_rand_valid got=%b exp=%b", out_data_available, v); else pass_cnt++;
    end
    enable_pool = 1'b1; in_data_available = 1'b0;
    tick();
  endtask

  task automatic test_max_w2();
    pool_window = 2'b01; in_data_available = 1'b1;
    inp_data = pack4(7, -3, 1, 5); tick();
    total_cnt++; if (out_data_available !== 1'b0) $display("FAIL w2_early got=%b exp=0", out_data_available); else pass_cnt++;
    total_cnt++; if (done_pool !== 1'b0) $display("FAIL w2_done_clear got=%b exp=0", done_pool); else pass_cnt++;
    inp_data = pack4(-1, 0, 9, 2); tick();
    total_cnt++; if (out_data !== pack4(7, 9, 0, 0)) $display("FAIL w2_data got=%h exp=%h", out_data, pack4(7, 9, 0, 0)); else pass_cnt++;
    total_cnt++; if (out_data_available !== 1'b1) $display("FAIL w2_valid got=%b exp=1", out_data_available); else pass_cnt++;
    in_data_available = 1'b0; tick();
    total_cnt++; if (out_data_available !== 1'b0) $display("FAIL w2_pulse got=%b exp=0", out_data_available); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL w2_zero got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (done_pool !== 1'b1) $display("FAIL w2_done got=%b exp=1", done_pool); else pass_cnt++;
  endtask

  task automatic test_max_w4_b2b();
    row_t q[$];
    row_t exp2;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) inp_data = pack4(t, 1 + t, 2 + t, 3 + t);
      else begin
        inp_data = row_t'($urandom);
        q.push_back(inp_data);
      end
      pool_window = (t == 0) ? 2'b10 : ((t == 4) ? 2'b11 : 2'b01);
      in_data_available = 1'b1;
      tick();
      total_cnt++;
      if (out_data_available !== ((t == 3) || (t == 7))) $display("FAIL w4_valid t=%0d got=%b exp=%b", t, out_data_available, (t == 3) || (t == 7));
      else pass_cnt++;
      if (t == 3) begin
        total_cnt++; if (out_data !== pack4(6, 0, 0, 0)) $display("FAIL w4_data got=%h exp=%h", out_data, pack4(6, 0, 0, 0)); else pass_cnt++;
      end
    end
    exp2 = ref_pool(q, 4, 1'b0);
    total_cnt++; if (out_data !== exp2) $display("FAIL w4_b2b_data got=%h exp=%h", out_data, exp2); else pass_cnt++;
    in_data_available = 1'b0; tick();
    total_cnt++; if (out_data_available !== 1'b0) $display("FAIL w4_tail got=%b exp=0", out_data_available); else pass_cnt++;
  endtask

  task automatic test_partial_flush();
    pool_window = 2'b01; in_data_available = 1'b1; inp_data = pack4(4, 3, 2, 1);
    tick();
    in_data_available = 1'b0; tick();
    total_cnt++; if (out_data !== pack4(4, 2, 0, 0)) $display("FAIL flush_data got=%h exp=%h", out_data, pack4(4, 2, 0, 0)); else pass_cnt++;
    total_cnt++; if (out_data_available !== 1'b1) $display("FAIL flush_valid got=%b exp=1", out_data_available); else pass_cnt++;
    total_cnt++; if (done_pool !== 1'b0) $display("FAIL flush_done_early got=%b exp=0", done_pool); else pass_cnt++;
    tick();
    total_cnt++; if (out_data_available !== 1'b0) $display("FAIL flush_pulse got=%b exp=0", out_data_available); else pass_cnt++;
    total_cnt++; if (done_pool !== 1'b1) $display("FAIL flush_done got=%b exp=1", done_pool); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    row_t q[$];
    row_t e;
    pool_window = 2'b10; in_data_available = 1'b1;
    for (int t = 0; t < 2; t++) begin inp_data = row_t'($urandom); tick(); end
    reset = 1'b1; in_data_available = 1'b0; tick(); reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      total_cnt++; if (out_data_available !== 1'b0) $display("FAIL rstmid_quiet t=%0d got=%b exp=0", t, out_data_available); else pass_cnt++;
      tick();
    end
    in_data_available = 1'b1;
    for (int t = 0; t < 4; t++) begin
      inp_data = row_t'($urandom); q.push_back(inp_data); tick();
      total_cnt++; if (out_data_available !== (t == 3)) $display("FAIL rstmid_valid t=%0d got=%b exp=%b", t, out_data_available, t == 3); else pass_cnt++;
    end
    e = ref_pool(q, 4, 1'b0);
    total_cnt++; if (out_data !== e) $display("FAIL rstmid_data got=%h exp=%h", out_data, e); else pass_cnt++;
    in_data_available = 1'b0; tick();
  endtask

  task automatic test_w1();
    row_t r;
    pool_window = 2'b00; in_data_available = 1'b1;
    for (int t = 0; t < 3; t++) begin
      r = row_t'($urandom); inp_data = r; tick();
      total_cnt++; if (out_data !== r || out_data_available !== 1'b1) $display("FAIL w1_pass t=%0d got=%h/%b exp=%h/1", t, out_data, out_data_available, r); else pass_cnt++;
    end
    in_data_available = 1'b0; tick();
    total_cnt++; if (done_pool !== 1'b1) $display("FAIL w1_done got=%b exp=1", done_pool); else pass_cnt++;
  endtask

`ifdef POOL_AVG_EN
  task automatic test_avg();
    pool_avg = 1'b1; pool_window = 2'b01; in_data_available = 1'b1;
    inp_data = pack4(4, 8, -4, 0); tick();
    inp_data = pack4(4, 0, -8, -4); tick();
    total_cnt++; if (out_data !== pack4(4, -4, 0, 0)) $display("FAIL avg_data got=%h exp=%h", out_data, pack4(4, -4, 0, 0)); else pass_cnt++;
    pool_avg = 1'b0; in_data_available = 1'b0; tick();
  endtask
`endif

  task automatic test_random();
    row_t q[$];
    int   cur_w;
    bit   cur_avg, prev_v, exp_done, v, a, exp_v;
    row_t row, exp_d;
    logic [1:0] enc;
    cur_w = 1; cur_avg = 1'b0; prev_v = 1'b0; exp_done = 1'b0;
    reset = 1'b1; in_data_available = 1'b0; tick(); reset = 1'b0;
    for (int c = 0; c < 300; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      row = row_t'($urandom);
      enc = 2'($urandom_range(0, 3));
      a   = 1'b0;
`ifdef POOL_AVG_EN
      a = 1'($urandom_range(0, 1));
      pool_avg = a;
`endif
      in_data_available = v; inp_data = row; pool_window = enc;
      tick();
      exp_v = 1'b0; exp_d = '0;
      if (v) begin
        if (q.size() == 0) begin cur_w = wsize(enc); cur_avg = a; end
        q.push_back(row);
        if (q.size() == cur_w) begin exp_v = 1'b1; exp_d = ref_pool(q, cur_w, cur_avg); q.delete(); end
      end else if (q.size() != 0) begin
        exp_v = 1'b1; exp_d = ref_pool(q, cur_w, cur_avg); q.delete();
      end
      if (prev_v && !v) exp_done = 1'b1;
      else if (v) exp_done = 1'b0;
      prev_v = exp_v;
      total_cnt++; if (out_data_available !== exp_v) $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_data_available, exp_v); else pass_cnt++;
      total_cnt++; if (out_data !== exp_d) $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, exp_d); else pass_cnt++;
      total_cnt++; if (done_pool !== exp_done) $display("FAIL rand_done c=%0d got=%b exp=%b", c, done_pool, exp_done); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_max_w2();
    test_max_w4_b2b();
    test_partial_flush();
    test_reset_mid();
    test_w1();
`ifdef POOL_AVG_EN
    test_avg();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
